// File: rtl/ibex_pkg.sv
// ibex_pkg: multdiv operator encoding, arbiter state type and operator helpers
package ibex_pkg;

  typedef enum logic [1:0] {
    MD_OP_MULL = 2'b00,
    MD_OP_MULH = 2'b01,
    MD_OP_DIV  = 2'b10,
    MD_OP_REM  = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'b00,
    ARB_EXEC = 2'b01,
    ARB_RESP = 2'b10
  } arb_state_e;

  function automatic logic is_div(md_op_e op);
    return op inside {MD_OP_DIV, MD_OP_REM};
  endfunction

endpackage

// File: rtl/ibex_rr_arbiter.sv
// ibex_rr_arbiter: combinational round-robin pick, first request at or after i_ptr wins
module ibex_rr_arbiter #(
  parameter int NUM_REQ = 2,
  localparam int IDX_W = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_ptr,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [IDX_W-1:0]   o_idx
);

  // scan from the farthest offset down so the nearest request overwrites last
  always_comb begin
    o_grant = '0;
    o_idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      logic [IDX_W-1:0] k;
      k = IDX_W'((int'(i_ptr) + i) % NUM_REQ);
      if (i_req[k]) begin
        o_grant = NUM_REQ'(1) << k;
        o_idx = k;
      end
    end
  end

endmodule

// File: rtl/ibex_multdiv_arbiter.sv
// ibex_multdiv_arbiter: round-robin sharing of one iterative mult/div unit with result buffering
module ibex_multdiv_arbiter
  import ibex_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W = 7
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [NUM_REQ-1:0]   req_valid_i,
  output logic [NUM_REQ-1:0]   req_ready_o,
  input  logic [NUM_REQ*2-1:0] req_op_i,
  input  logic [NUM_REQ*2-1:0] req_signed_mode_i,
  input  logic [NUM_REQ*32-1:0] req_op_a_i,
  input  logic [NUM_REQ*32-1:0] req_op_b_i,
  output logic [NUM_REQ-1:0]   rsp_valid_o,
  input  logic [NUM_REQ-1:0]   rsp_ready_i,
  output logic [31:0]          rsp_result_o,
  input  logic                 flush_i,
  output logic                 timeout_o,
  output logic                 busy_o,
  output logic                 md_mult_en_o,
  output logic                 md_div_en_o,
  output logic [1:0]           md_operator_o,
  output logic [1:0]           md_signed_mode_o,
  output logic [31:0]          md_op_a_o,
  output logic [31:0]          md_op_b_o,
  input  logic                 md_valid_i,
  input  logic [31:0]          md_result_i
);

  localparam int IDX_W = $clog2(NUM_REQ);

  arb_state_e       r_state, w_state_nxt;
  logic [IDX_W-1:0] r_grant, r_rr_ptr, w_idx, w_ptr_nxt;
  logic [NUM_REQ-1:0] w_gnt;
  md_op_e           r_op;
  logic [1:0]       r_signed;
  logic [31:0]      r_op_a, r_op_b, r_result;
  logic [CNT_W-1:0] r_cnt;
  logic             w_accept, w_advance, w_timeout, w_capture, w_wd_hit;
  md_op_e           w_op [NUM_REQ];
  logic [1:0]       w_signed [NUM_REQ];
  logic [31:0]      w_a [NUM_REQ];
  logic [31:0]      w_b [NUM_REQ];

  for (genvar r = 0; r < NUM_REQ; r++) begin : g_unpack
    assign w_op[r]     = md_op_e'(req_op_i[2*r +: 2]);
    assign w_signed[r] = req_signed_mode_i[2*r +: 2];
    assign w_a[r]      = req_op_a_i[32*r +: 32];
    assign w_b[r]      = req_op_b_i[32*r +: 32];
  end

  ibex_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .i_req   (req_valid_i),
    .i_ptr   (r_rr_ptr),
    .o_grant (w_gnt),
    .o_idx   (w_idx)
  );

  assign w_wd_hit  = (TIMEOUT_CYCLES != 0) && (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign w_ptr_nxt = (r_grant == IDX_W'(NUM_REQ - 1)) ? '0 : r_grant + IDX_W'(1);
  assign w_capture = (r_state == ARB_EXEC) && !flush_i && md_valid_i;

  // flush outranks a same-cycle unit result; a same-cycle result outranks the watchdog
  always_comb begin
    w_state_nxt = r_state;
    w_accept = 1'b0;
    w_advance = 1'b0;
    w_timeout = 1'b0;
    case (r_state)
      ARB_IDLE: begin
        w_accept = !flush_i && |req_valid_i;
        w_state_nxt = w_accept ? ARB_EXEC : ARB_IDLE;
      end
      ARB_EXEC: begin
        if (flush_i) begin
          w_state_nxt = ARB_IDLE;
          w_advance = 1'b1;
        end else if (md_valid_i) begin
          w_state_nxt = ARB_RESP;
        end else if (w_wd_hit) begin
          w_state_nxt = ARB_IDLE;
          w_advance = 1'b1;
          w_timeout = 1'b1;
        end
      end
      ARB_RESP: begin
        w_advance = flush_i || rsp_ready_i[r_grant];
        w_state_nxt = w_advance ? ARB_IDLE : ARB_RESP;
      end
      default: w_state_nxt = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= ARB_IDLE;
    else r_state <= w_state_nxt;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_grant <= '0;
      r_rr_ptr <= '0;
      r_op <= MD_OP_MULL;
      r_signed <= '0;
      r_op_a <= '0;
      r_op_b <= '0;
      r_result <= '0;
      r_cnt <= '0;
    end else begin
      if (w_accept) begin
        r_grant <= w_idx;
        r_op <= w_op[w_idx];
        r_signed <= w_signed[w_idx];
        r_op_a <= w_a[w_idx];
        r_op_b <= w_b[w_idx];
        r_cnt <= '0;
      end else if (r_state == ARB_EXEC) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      if (w_capture) r_result <= md_result_i;
      if (w_advance) r_rr_ptr <= w_ptr_nxt;
    end
  end

  assign req_ready_o      = w_accept ? w_gnt : '0;
  assign rsp_valid_o      = (r_state == ARB_RESP) ? NUM_REQ'(1) << r_grant : '0;
  assign rsp_result_o     = r_result;
  assign timeout_o        = w_timeout;
  assign busy_o           = r_state != ARB_IDLE;
  assign md_mult_en_o     = (r_state == ARB_EXEC) && !is_div(r_op);
  assign md_div_en_o      = (r_state == ARB_EXEC) && is_div(r_op);
  assign md_operator_o    = r_op;
  assign md_signed_mode_o = r_signed;
  assign md_op_a_o        = r_op_a;
  assign md_op_b_o        = r_op_b;

endmodule

// File: tb/tb_ibex_multdiv_arbiter.sv
// tb_ibex_multdiv_arbiter: directed vectors against a fixed-latency mult/div unit model
module tb_ibex_multdiv_arbiter;
  import ibex_pkg::*;

  logic        clk = 1'b0, rst = 1'b1;
  logic [1:0]  req_valid = '0, req_ready, rsp_valid, rsp_ready = '0;
  logic [3:0]  req_op = '0, req_sm = '0;
  logic [63:0] req_a = '0, req_b = '0;
  logic [31:0] rsp_result, md_a, md_b, md_result;
  logic        flush = 1'b0, timeout, busy, mult_en, div_en, md_valid;
  logic [1:0]  md_operator, md_sm;
  int          n_chk = 0, n_pass = 0, ucnt = 0, lat = 3;
  bit          unit_on = 1'b1;

  always #5 clk = ~clk;

  ibex_multdiv_arbiter #(.NUM_REQ(2), .TIMEOUT_CYCLES(8), .CNT_W(4)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_op_i(req_op), .req_signed_mode_i(req_sm),
    .req_op_a_i(req_a), .req_op_b_i(req_b),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_result_o(rsp_result),
    .flush_i(flush), .timeout_o(timeout), .busy_o(busy),
    .md_mult_en_o(mult_en), .md_div_en_o(div_en),
    .md_operator_o(md_operator), .md_signed_mode_o(md_sm),
    .md_op_a_o(md_a), .md_op_b_o(md_b),
    .md_valid_i(md_valid), .md_result_i(md_result)
  );

  function automatic logic [31:0] unit_res(logic [1:0] op, logic [31:0] a, logic [31:0] b);
    logic [63:0] p;
    p = {32'b0, a} * {32'b0, b};
    case (op)
      2'd0: return p[31:0];
      2'd1: return p[63:32];
      2'd2: return (b == 0) ? '1 : a / b;
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  always @(posedge clk) ucnt <= (mult_en || div_en) ? ucnt + 1 : 0;
  assign md_valid  = unit_on && (mult_en || div_en) && (ucnt == lat - 1);
  assign md_result = unit_res(md_operator, md_a, md_b);

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #3;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    tick;
    tick;
    rst = 1'b0;
    #1;
  endtask

  task automatic set_req(int r, md_op_e op, logic [1:0] sm, logic [31:0] a, logic [31:0] b);
    req_op[2*r +: 2] = op;
    req_sm[2*r +: 2] = sm;
    req_a[32*r +: 32] = a;
    req_b[32*r +: 32] = b;
  endtask

  task automatic wait_gnt;
    for (int w = 0; w < 20 && req_ready == '0; w++) tick;
  endtask

  task automatic wait_rsp;
    for (int w = 0; w < 30 && rsp_valid == '0; w++) tick;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    do_reset;
    chk("rst_busy", busy, 0);
    chk("rst_ready", req_ready, 0);
    chk("rst_rsp", rsp_valid, 0);

    // single MULL request from requester 0
    set_req(0, MD_OP_MULL, 2'b00, 7, 6);
    req_valid = 2'b01;
    #1;
    chk("t1_ready", req_ready, 2'b01);
    tick;
    req_valid = 2'b00;
    #1;
    chk("t1_mul_en1", mult_en, 1);
    chk("t1_div_en", div_en, 0);
    chk("t1_op_a", md_a, 7);
    chk("t1_op_b", md_b, 6);
    tick;
    chk("t1_mul_en2", mult_en, 1);
    tick;
    chk("t1_mul_en3", mult_en, 1);
    tick;
    chk("t1_mul_en4", mult_en, 0);
    chk("t1_rsp", rsp_valid, 2'b01);
    chk("t1_res", rsp_result, 42);
    tick;
    chk("t1_rsp_hold", rsp_valid, 2'b01);
    rsp_ready = 2'b01;
    #1;
    tick;
    rsp_ready = 2'b00;
    #1;
    chk("t1_rsp_done", rsp_valid, 0);
    chk("t1_idle", busy, 0);

    // fairness with both requesters always valid
    do_reset;
    set_req(0, MD_OP_MULL, 2'b00, 3, 5);
    set_req(1, MD_OP_DIV, 2'b00, 20, 4);
    req_valid = 2'b11;
    rsp_ready = 2'b11;
    #1;
    for (int t = 0; t < 4; t++) begin
      wait_gnt;
      chk("t2_gnt", req_ready, (t % 2 == 0) ? 2'b01 : 2'b10);
      wait_rsp;
      chk("t2_rsp", rsp_valid, (t % 2 == 0) ? 2'b01 : 2'b10);
      chk("t2_res", rsp_result, (t % 2 == 0) ? 15 : 5);
      tick;
    end
    req_valid = 2'b00;
    rsp_ready = 2'b00;
    #1;

    // back-pressure on a DIV response for requester 1
    set_req(1, MD_OP_DIV, 2'b11, 100, 7);
    req_valid = 2'b10;
    #1;
    chk("t3_gnt", req_ready, 2'b10);
    tick;
    req_valid = 2'b00;
    #1;
    chk("t3_operator", md_operator, 2);
    chk("t3_signed", md_sm, 2'b11);
    chk("t3_div_en", div_en, 1);
    chk("t3_mul_en", mult_en, 0);
    wait_rsp;
    req_valid = 2'b11;
    #1;
    for (int c = 0; c < 10; c++) begin
      chk("t3_rsp", rsp_valid, 2'b10);
      chk("t3_res", rsp_result, 14);
      chk("t3_no_gnt", req_ready, 0);
      tick;
    end
    rsp_ready = 2'b01;
    #1;
    tick;
    chk("t3_ignore_other", rsp_valid, 2'b10);
    rsp_ready = 2'b10;
    #1;
    tick;
    rsp_ready = 2'b00;
    #1;
    chk("t3_next_gnt", req_ready, 2'b01);
    req_valid = 2'b00;
    #1;

    // flush in the second EXEC cycle, coinciding with the unit result
    lat = 2;
    set_req(0, MD_OP_REM, 2'b00, 17, 5);
    req_valid = 2'b01;
    #1;
    chk("t4_gnt", req_ready, 2'b01);
    tick;
    req_valid = 2'b00;
    #1;
    chk("t4_div_en", div_en, 1);
    tick;
    flush = 1'b1;
    #1;
    tick;
    flush = 1'b0;
    set_req(1, MD_OP_MULL, 2'b00, 2, 2);
    req_valid = 2'b10;
    #1;
    chk("t4_en_off", div_en, 0);
    chk("t4_no_rsp", rsp_valid, 0);
    chk("t4_busy", busy, 0);
    chk("t4_next_gnt", req_ready, 2'b10);
    tick;
    req_valid = 2'b00;
    #1;
    wait_rsp;
    chk("t4_rsp", rsp_valid, 2'b10);
    chk("t4_res", rsp_result, 4);
    rsp_ready = 2'b10;
    #1;
    tick;
    rsp_ready = 2'b00;
    lat = 3;

    // watchdog with a silent unit, then a result in the last allowed cycle
    unit_on = 1'b0;
    set_req(0, MD_OP_MULL, 2'b00, 1, 1);
    req_valid = 2'b01;
    #1;
    chk("t5_gnt", req_ready, 2'b01);
    tick;
    req_valid = 2'b00;
    #1;
    for (int k = 1; k <= 8; k++) begin
      chk("t5_timeout", timeout, k == 8);
      tick;
    end
    chk("t5_busy", busy, 0);
    chk("t5_pulse_end", timeout, 0);
    chk("t5_en_off", mult_en, 0);
    chk("t5_no_rsp", rsp_valid, 0);
    set_req(1, MD_OP_MULL, 2'b00, 9, 9);
    req_valid = 2'b11;
    #1;
    chk("t5_ptr_adv", req_ready, 2'b10);
    unit_on = 1'b1;
    lat = 8;
    tick;
    req_valid = 2'b00;
    #1;
    for (int k = 1; k <= 8; k++) begin
      chk("t5_no_timeout", timeout, 0);
      tick;
    end
    chk("t5_late_rsp", rsp_valid, 2'b10);
    chk("t5_late_res", rsp_result, 81);
    rsp_ready = 2'b10;
    #1;
    tick;
    rsp_ready = 2'b00;
    lat = 3;

    // reset in the middle of EXEC with rr_ptr pointing at requester 1
    set_req(0, MD_OP_MULL, 2'b00, 3, 5);
    req_valid = 2'b01;
    #1;
    tick;
    req_valid = 2'b00;
    #1;
    wait_rsp;
    chk("t6_pre_res", rsp_result, 15);
    rsp_ready = 2'b01;
    #1;
    tick;
    rsp_ready = 2'b00;
    set_req(1, MD_OP_DIV, 2'b11, 100, 7);
    req_valid = 2'b10;
    #1;
    chk("t6_gnt", req_ready, 2'b10);
    tick;
    req_valid = 2'b00;
    tick;
    chk("t6_div_en", div_en, 1);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    #1;
    chk("t6_ready", req_ready, 0);
    chk("t6_rsp", rsp_valid, 0);
    chk("t6_res", rsp_result, 0);
    chk("t6_busy", busy, 0);
    chk("t6_timeout", timeout, 0);
    chk("t6_mul_en", mult_en, 0);
    chk("t6_div_en_off", div_en, 0);
    chk("t6_operator", md_operator, 0);
    chk("t6_signed", md_sm, 0);
    chk("t6_op_a", md_a, 0);
    chk("t6_op_b", md_b, 0);
    req_valid = 2'b11;
    #1;
    chk("t6_first_gnt", req_ready, 2'b01);
    req_valid = 2'b00;
    #1;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/ibex_multdiv_arbiter.md
Name: ibex_multdiv_arbiter

Overview:
Shares one iterative multiplier/divider unit between NUM_REQ requesters, for example the core pipeline and a coprocessor/debug port. Each requester uses a valid/ready request channel and a valid/ready response channel. Grants are round-robin, and the block registers the operands of the granted request. It drives the unit's mult/div enables until the unit signals valid, then buffers the result until the requester accepts it. Supports flush and a watchdog timeout.

Parameters:
NUM_REQ, 2, number of requesters (2..4)
TIMEOUT_CYCLES, 64, max cycles in EXEC before abort; 0 disables the watchdog
CNT_W, 7, watchdog counter width; must satisfy 2**CNT_W > TIMEOUT_CYCLES

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous reset, active-high
req_valid_i  in  NUM_REQ  request valid, one bit per requester
req_ready_o  out  NUM_REQ  request accepted this cycle, one-hot or zero
req_op_i  in  NUM_REQ*2  md_op_e per requester, requester r at bits [2r+1:2r]
req_signed_mode_i  in  NUM_REQ*2  signed mode per requester
req_op_a_i  in  NUM_REQ*32  operand A per requester
req_op_b_i  in  NUM_REQ*32  operand B per requester
rsp_valid_o  out  NUM_REQ  response valid, one-hot or zero
rsp_ready_i  in  NUM_REQ  response accept
rsp_result_o  out  32  buffered result, shared by all requesters
flush_i  in  1  abort the in-flight operation
timeout_o  out  1  one-cycle pulse when the watchdog aborts
busy_o  out  1  state != IDLE
md_mult_en_o  out  1  to unit mult_en_i
md_div_en_o  out  1  to unit div_en_i
md_operator_o  out  2  to unit operator_i
md_signed_mode_o  out  2  to unit signed_mode_i
md_op_a_o  out  32  to unit op_a_i
md_op_b_o  out  32  to unit op_b_i
md_valid_i  in  1  unit valid_o, single-cycle pulse
md_result_i  in  32  unit multdiv_result_o, valid when md_valid_i=1

Behaviour:
- Reset (rst_i=1 at a clock edge) sets state=IDLE, rr_ptr=0, grant=0, op/operand registers=0, result buffer=0, watchdog=0. Consequently all outputs are 0 in the cycle after reset. Reset mid-operation drops everything without draining the unit; the unit sees its enables low the next cycle.
- States: IDLE, EXEC, RESP.
- IDLE:
  - If flush_i=0 and any req_valid_i is set, select the first valid requester scanning rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  - req_ready_o[g]=1 in the same cycle. This is combinational from req_valid_i; it is not combinational from rsp_ready_i.
  - Register g, op, signed mode and operands; go to EXEC.
  - flush_i=1 blocks acceptance.
- EXEC:
  - md_* outputs come from the registered fields.
  - md_mult_en_o=1 for MD_OP_MULL/MD_OP_MULH; md_div_en_o=1 for MD_OP_DIV/MD_OP_REM. They are never both 1.
  - On md_valid_i=1: capture md_result_i; go to RESP. Enables are 0 from the next cycle, which prevents the unit restarting.
- RESP:
  - rsp_valid_o[g]=1 and rsp_result_o=buffer. Both stay stable until rsp_ready_i[g]=1.
  - On handshake: rr_ptr<=(g+1) mod NUM_REQ; go to IDLE. A new grant is possible the following cycle, so there is one bubble.
- Latency: accept at cycle 0, enables from cycle 1, unit valid at cycle k, rsp_valid at k+1.
- flush_i:
  - EXEC: go to IDLE; enables are 0 next cycle; the result is discarded; rr_ptr advances past g.
  - RESP: the response is dropped; go to IDLE.
  - If flush_i and md_valid_i occur in the same cycle, flush wins.
- Watchdog:
  - Counts cycles in EXEC and clears on entry.
  - When count==TIMEOUT_CYCLES-1 and md_valid_i=0: pulse timeout_o, go to IDLE, advance rr_ptr. No response is issued.
  - If md_valid_i arrives in the same cycle, the result is taken and no timeout fires.
- rsp_ready_i of non-granted requesters is ignored. req_valid_i may drop without penalty while the requester is not granted.
- rr_ptr wraps from NUM_REQ-1 to 0.

Decomposition:
- md_op_e, the arbiter state enum (arb_state_e: ARB_IDLE/ARB_EXEC/ARB_RESP) and the helper function is_div(md_op_e) belong in ibex_pkg.
- One sub-module: ibex_rr_arbiter. It is combinational and parameterised by NUM_REQ. Inputs are req vector and rr_ptr; outputs are a one-hot grant and its index. It is reusable elsewhere in the codebase.

Test Plan:
1. Single request: req 0 issues MULL with a=7, b=6; the unit model pulses valid 3 cycles after enable with result 42. Required: req_ready_o=01 at cycle 0, md_mult_en_o=1 for cycles 1-3, rsp_valid_o=01 and rsp_result_o=42 from cycle 4 until ready, enables 0 from cycle 4.
2. Fairness: both requesters hold valid for 4 transactions. Grants must be 0,1,0,1; req_ready_o is never 11.
3. Back-pressure: rsp_ready_i[1]=0 for 10 cycles after DIV with a=100, b=7. Required: rsp_result_o=14 held stable, rsp_valid_o=10 throughout, no new grant.
4. Flush: flush_i in the 2nd cycle of EXEC for REM. Required: enables 0 next cycle, no rsp_valid, busy_o=0; a following request by the other requester is granted the next cycle.
5. Timeout: TIMEOUT_CYCLES=8 with the unit never responding. Required: timeout_o pulses at EXEC cycle 8, state returns to IDLE, rr_ptr advances. Repeat with md_valid_i arriving at cycle 8: a response is issued and there is no timeout.
6. Reset mid-EXEC: rst_i=1 for 1 cycle. Required: all outputs 0 next cycle, and the first grant afterwards goes to requester 0.
